// File: rtl/leg_core_p.sv
// leg_core_p: parametrised single-issue LEG-style core. Holds a loadable program store,
// an IDLE/RUN/HALT control FSM and a valid/ready I/O port. Retires one instruction per
// clock in RUN unless the I/O port stalls it.
module leg_core_p #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned NUM_REGS   = 6,
    parameter int unsigned PROG_DEPTH = 256,
    localparam int unsigned PC_W      = $clog2(PROG_DEPTH),
    localparam int unsigned INSTR_W   = 8 + 3 * DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_wdata,
    input  logic [DATA_W-1:0]  io_in,
    input  logic               io_in_valid,
    output logic               io_in_ready,
    output logic [DATA_W-1:0]  io_out,
    output logic               io_out_valid,
    input  logic               io_out_ready,
    output logic               halted,
    output logic [PC_W-1:0]    pc
);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    // Operand address map: registers first, then the PC, then the I/O port.
    localparam logic [DATA_W-1:0] PcAddr = DATA_W'(NUM_REGS);
    localparam logic [DATA_W-1:0] IoAddr = DATA_W'(NUM_REGS + 1);
    localparam logic [DATA_W-1:0] DataWV = DATA_W'(DATA_W);
    localparam logic [PC_W-1:0]   PcLast = PC_W'(PROG_DEPTH - 1);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d, pc_inc;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   io_out_q;
    logic                io_out_valid_q;
    logic [INSTR_W-1:0]  prog_mem [PROG_DEPTH];

    logic [INSTR_W-1:0]  instr;
    logic [7:0]          opcode;
    logic [DATA_W-1:0]   arg_a, arg_b, dest;
    logic                imm_a, imm_b, cond_op, halt_op;
    logic [2:0]          alu_op;
    logic                unused_op_bit;

    logic [DATA_W-1:0]   src_a, src_b, op_a, op_b, sh_amt, alu_res;
    logic                cond_true;
    logic                reads_io, writes_io, in_ok, out_ok, exec, retire;
    logic                reg_we, io_we;

    // Combinational fetch and field split.
    assign instr         = prog_mem[pc_q];
    assign opcode        = instr[INSTR_W-1 -: 8];
    assign arg_a         = instr[3*DATA_W-1 -: DATA_W];
    assign arg_b         = instr[2*DATA_W-1 -: DATA_W];
    assign dest          = instr[DATA_W-1:0];
    assign imm_a         = opcode[7];
    assign imm_b         = opcode[6];
    assign cond_op       = opcode[5];
    assign halt_op       = opcode[4];
    assign alu_op        = opcode[2:0];
    assign unused_op_bit = opcode[3];

    // Operand read: registers, PC, I/O, or zero for unmapped addresses; literals bypass.
    always_comb begin
        src_a = '0;
        src_b = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (arg_a == DATA_W'(i)) src_a = regs_q[i];
            if (arg_b == DATA_W'(i)) src_b = regs_q[i];
        end
        if (arg_a == PcAddr) src_a = DATA_W'(pc_q);
        if (arg_b == PcAddr) src_b = DATA_W'(pc_q);
        if (arg_a == IoAddr) src_a = io_in;
        if (arg_b == IoAddr) src_b = io_in;
        op_a = imm_a ? arg_a : src_a;
        op_b = imm_b ? arg_b : src_b;
    end

    // ALU result and branch condition (unsigned compares).
    always_comb begin
        alu_res   = '0;
        cond_true = 1'b0;
        sh_amt    = op_b % DataWV;
        case (alu_op)
            3'd0:    alu_res = op_a + op_b;
            3'd1:    alu_res = op_a - op_b;
            3'd2:    alu_res = op_a & op_b;
            3'd3:    alu_res = op_a | op_b;
            3'd4:    alu_res = ~op_a;
            3'd5:    alu_res = op_a ^ op_b;
            3'd6:    alu_res = op_a << sh_amt;
            default: alu_res = op_a >> sh_amt;
        endcase
        case (alu_op)
            3'd0:    cond_true = (op_a == op_b);
            3'd1:    cond_true = (op_a != op_b);
            3'd2:    cond_true = (op_a < op_b);
            3'd3:    cond_true = (op_a <= op_b);
            3'd4:    cond_true = (op_a > op_b);
            3'd5:    cond_true = (op_a >= op_b);
            3'd6:    cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // I/O stall conditions; HALT overrides every other opcode bit so it never touches I/O.
    assign reads_io  = !halt_op && ((!imm_a && arg_a == IoAddr) || (!imm_b && arg_b == IoAddr));
    assign writes_io = !halt_op && !cond_op && (dest == IoAddr);
    assign in_ok     = !reads_io || io_in_valid;
    assign out_ok    = !writes_io || !io_out_valid_q || io_out_ready;
    assign exec      = (state_q == StRun) && run;
    assign retire    = exec && in_ok && out_ok;
    assign reg_we    = retire && !halt_op && !cond_op;
    assign io_we     = reg_we && (dest == IoAddr);
    assign pc_inc    = (pc_q == PcLast) ? '0 : pc_q + 1'b1;

    // Control FSM next state and PC update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            StIdle: begin
                if (run) state_d = StRun;
            end
            StRun: begin
                if (!run) begin
                    state_d = StIdle;
                end else if (retire) begin
                    if (halt_op) begin
                        state_d = StHalt;
                    end else if (cond_op) begin
                        pc_d = cond_true ? PC_W'(dest) : pc_inc;
                    end else if (dest == PcAddr) begin
                        pc_d = PC_W'(alu_res);
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            StHalt: begin
                if (!run) begin
                    state_d = StIdle;
                    pc_d    = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and PC registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Register file; writes to unmapped addresses fall through every compare and are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (reg_we && dest == DATA_W'(i)) regs_q[i] <= alu_res;
            end
        end
    end

    // Output holding register: a new write takes priority over the consumer draining it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_out_q       <= '0;
            io_out_valid_q <= 1'b0;
        end else if (io_we) begin
            io_out_q       <= alu_res;
            io_out_valid_q <= 1'b1;
        end else if (io_out_ready) begin
            io_out_valid_q <= 1'b0;
        end
    end

    // Program store: unreset, writable only while the core is not executing.
    always_ff @(posedge clk) begin
        if (prog_we && state_q != StRun) prog_mem[prog_addr] <= prog_wdata;
    end

    assign io_in_ready  = exec && reads_io;
    assign io_out       = io_out_q;
    assign io_out_valid = io_out_valid_q;
    assign halted       = (state_q == StHalt);
    assign pc           = pc_q;

endmodule

// File: tb/tb_leg_core_p.sv
// tb_leg_core_p: directed and randomized checks of leg_core_p. Expected I/O outputs are queued
// when a program is built; a negedge monitor pops them on every accepted transfer.
module tb_leg_core_p;

    localparam logic [7:0] IO_A = 8'd7;
    localparam logic [7:0] PC_A = 8'd6;

    logic        clk = 1'b0;
    logic        rst, run, prog_we, io_in_valid, io_in_ready, io_out_valid, io_out_ready, halted;
    logic [7:0]  prog_addr, io_in, io_out, pc;
    logic [31:0] prog_wdata;

    logic        run2, prog_we2, io_in_valid2, io_in_ready2, io_out_valid2, io_out_ready2, halted2;
    logic [3:0]  prog_addr2, pc2;
    logic [55:0] prog_wdata2;
    logic [15:0] io_in2, io_out2;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] exp2_q[$];
    logic [7:0]  in_vals[$];
    logic [31:0] prog[$];
    logic [7:0]  m_regs[6];
    int          in_idx;
    bit          src_en, snk_en;

    always #5 clk = ~clk;

    leg_core_p dut (
        .clk(clk), .rst(rst), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .io_in(io_in), .io_in_valid(io_in_valid),
        .io_in_ready(io_in_ready), .io_out(io_out), .io_out_valid(io_out_valid),
        .io_out_ready(io_out_ready), .halted(halted), .pc(pc)
    );

    leg_core_p #(.DATA_W(16), .NUM_REGS(8), .PROG_DEPTH(16)) dut2 (
        .clk(clk), .rst(rst), .run(run2), .prog_we(prog_we2), .prog_addr(prog_addr2),
        .prog_wdata(prog_wdata2), .io_in(io_in2), .io_in_valid(io_in_valid2),
        .io_in_ready(io_in_ready2), .io_out(io_out2), .io_out_valid(io_out_valid2),
        .io_out_ready(io_out_ready2), .halted(halted2), .pc(pc2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted output transfer must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && io_out_valid && io_out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL io_out_unexpected: got %0h expected no transfer", io_out);
            end else begin
                check("io_out", 32'(io_out), 32'(exp_q.pop_front()));
            end
        end
        if (rst && io_out_valid2 && io_out_ready2) begin
            if (exp2_q.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL io_out2_unexpected: got %0h expected no transfer", io_out2);
            end else begin
                check("io_out2", 32'(io_out2), 32'(exp2_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ins(input logic [7:0] opc, a, b, d);
        return {opc, a, b, d};
    endfunction

    function automatic logic [55:0] ins16(input logic [7:0] opc, input logic [15:0] a, b, d);
        return {opc, a, b, d};
    endfunction

    // One clock: sample the input handshake, then drive new random source/sink values.
    task automatic step();
        logic fire;
        @(negedge clk);
        fire = io_in_valid && io_in_ready;
        @(posedge clk);
        #1;
        if (src_en) begin
            if (fire) in_idx++;
            if (in_idx < in_vals.size()) begin
                io_in       = in_vals[in_idx];
                io_in_valid = ($urandom_range(0, 2) != 0);
            end else begin
                io_in_valid = 1'b0;
            end
        end
        if (snk_en) io_out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic load();
        for (int i = 0; i < prog.size(); i++) begin
            prog_we    = 1'b1;
            prog_addr  = 8'(i);
            prog_wdata = prog[i];
            step();
        end
        prog_we = 1'b0;
    endtask

    task automatic run_to_halt(input int budget, output int cycles);
        run    = 1'b1;
        cycles = 0;
        while (!halted && cycles < budget) begin
            step();
            cycles++;
        end
        if (!halted) begin
            n_checks++; n_err++;
            $display("FAIL halt_timeout: got pc=%0h expected halted within %0d cycles", pc, budget);
        end
    endtask

    task automatic drain();
        io_out_ready = 1'b1;
        repeat (3) step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("io_out_valid_idle", 32'(io_out_valid), 32'd0);
    endtask

    task automatic stop();
        run = 1'b0;
        step();
        check("pc_after_halt_exit", 32'(pc), 32'd0);
        check("halted_after_exit", 32'(halted), 32'd0);
    endtask

    function automatic logic [7:0] pick_src();
        int unsigned r = $urandom_range(0, 8);
        if (r < 6) return 8'(r);
        if (r == 6) return PC_A;
        if (r == 7) return IO_A;
        return 8'd9;
    endfunction

    function automatic logic [7:0] mval(input logic [7:0] addr, input int idx, input logic [7:0] inv);
        if (addr < 8'd6) return m_regs[addr];
        if (addr == PC_A) return 8'(idx);
        if (addr == IO_A) return inv;
        return 8'd0;
    endfunction

    // Build a random straight-line program, interpret it, and queue its expected outputs.
    task automatic gen_random(input int n, output int halt_idx);
        logic [7:0]  opc, a, b, d, va, vb, res, inv;
        logic        ia, ib, rd_io;
        int unsigned op, r;
        prog.delete();
        in_vals.delete();
        for (int k = 0; k < n; k++) begin
            op = $urandom_range(0, 7);
            ia = 1'($urandom_range(0, 1));
            ib = 1'($urandom_range(0, 1));
            a  = ia ? 8'($urandom) : pick_src();
            b  = ib ? 8'($urandom) : pick_src();
            r  = $urandom_range(0, 9);
            d  = (r < 6) ? 8'(r) : (r < 8) ? IO_A : 8'd9;
            if (d == IO_A) begin
                if (!ia && a == IO_A) a = 8'd0;
                if (!ib && b == IO_A) b = 8'd1;
            end
            rd_io = (!ia && a == IO_A) || (!ib && b == IO_A);
            inv   = 8'($urandom);
            if (rd_io) in_vals.push_back(inv);
            va = ia ? a : mval(a, k, inv);
            vb = ib ? b : mval(b, k, inv);
            case (op)
                0: res = va + vb;
                1: res = va - vb;
                2: res = va & vb;
                3: res = va | vb;
                4: res = ~va;
                5: res = va ^ vb;
                6: res = va << (vb % 8);
                default: res = va >> (vb % 8);
            endcase
            if (d < 8'd6) m_regs[d] = res;
            else if (d == IO_A) exp_q.push_back(res);
            opc = {ia, ib, 2'b00, 1'($urandom_range(0, 1)), 3'(op)};
            prog.push_back(ins(opc, a, b, d));
        end
        for (int i = 0; i < 6; i++) begin
            prog.push_back(ins(8'h40, 8'(i), 8'd0, IO_A));
            exp_q.push_back(m_regs[i]);
        end
        prog.push_back(ins(8'h10, 8'd0, 8'd0, 8'd0));
        halt_idx = prog.size() - 1;
    endtask

    initial begin
        int cyc, hidx;
        rst = 1'b0; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        io_in = '0; io_in_valid = 1'b0; io_out_ready = 1'b0;
        run2 = 1'b0; prog_we2 = 1'b0; prog_addr2 = '0; prog_wdata2 = '0;
        io_in2 = '0; io_in_valid2 = 1'b0; io_out_ready2 = 1'b1;
        src_en = 1'b0; snk_en = 1'b0; in_idx = 0;
        for (int i = 0; i < 6; i++) m_regs[i] = 8'd0;

        // Reset state
        #3;
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_io_out", 32'(io_out), 32'd0);
        check("rst_io_out_valid", 32'(io_out_valid), 32'd0);
        check("rst_io_in_ready", 32'(io_in_ready), 32'd0);
        #9 rst = 1'b1;
        step();

        // ALU smoke test: one IDLE->RUN cycle then four retires
        prog = '{ins(8'hC0, 8'd200, 8'd100, 8'd0), ins(8'hC1, 8'd5, 8'd7, 8'd1),
                 ins(8'h46, 8'd0, 8'd9, 8'd2), ins(8'h10, 8'd0, 8'd0, 8'd0)};
        load();
        run_to_halt(20, cyc);
        check("smoke_cycles", 32'(cyc), 32'd5);
        check("smoke_pc", 32'(pc), 32'd3);
        check("smoke_halted", 32'(halted), 32'd1);
        stop();
        prog = '{ins(8'h40, 8'd0, 8'd0, IO_A), ins(8'h40, 8'd1, 8'd0, IO_A),
                 ins(8'h40, 8'd2, 8'd0, IO_A), ins(8'h10, 8'd0, 8'd0, 8'd0)};
        exp_q = '{8'd44, 8'hFE, 8'h58};
        load();
        io_out_ready = 1'b1;
        run_to_halt(40, cyc);
        drain();
        stop();

        // Counting loop with a conditional jump
        prog = '{ins(8'hC0, 8'd0, 8'd0, 8'd0), ins(8'h40, 8'd0, 8'd1, 8'd0),
                 ins(8'h62, 8'd0, 8'd10, 8'd1), ins(8'h40, 8'd0, 8'd0, IO_A),
                 ins(8'h10, 8'd0, 8'd0, 8'd0)};
        exp_q = '{8'd10};
        load();
        run_to_halt(100, cyc);
        check("loop_pc", 32'(pc), 32'd4);
        drain();
        stop();

        // Input stall: both operands read the same I/O value
        prog = '{ins(8'h00, IO_A, IO_A, 8'd0), ins(8'h40, 8'd0, 8'd0, IO_A),
                 ins(8'h10, 8'd0, 8'd0, 8'd0)};
        exp_q = '{8'h42};
        load();
        run = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", 32'(io_in_ready), 32'd1);
            check("stall_in_pc", 32'(pc), 32'd0);
            step();
        end
        io_in = 8'h21; io_in_valid = 1'b1;
        step();
        io_in_valid = 1'b0;
        check("stall_in_pc_adv", 32'(pc), 32'd1);
        run_to_halt(20, cyc);
        drain();
        stop();

        // Output back-pressure
        prog = '{ins(8'hC0, 8'hAA, 8'd0, IO_A), ins(8'hC0, 8'h55, 8'd0, IO_A),
                 ins(8'h10, 8'd0, 8'd0, 8'd0)};
        exp_q = '{8'hAA, 8'h55};
        io_out_ready = 1'b0;
        load();
        run = 1'b1;
        step();
        step();
        check("bp_first_out", 32'(io_out), 32'hAA);
        check("bp_first_valid", 32'(io_out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_stall_pc", 32'(pc), 32'd1);
            check("bp_hold_out", 32'(io_out), 32'hAA);
        end
        io_out_ready = 1'b1;
        step();
        check("bp_second_out", 32'(io_out), 32'h55);
        check("bp_second_pc", 32'(pc), 32'd2);
        run_to_halt(10, cyc);
        drain();
        stop();

        // Run deassert mid-program and ignored prog_we in RUN
        prog = '{ins(8'hC0, 8'd0, 8'd0, 8'd0)};
        for (int i = 0; i < 7; i++) prog.push_back(ins(8'h40, 8'd0, 8'd1, 8'd0));
        prog.push_back(ins(8'h40, 8'd0, 8'd0, IO_A));
        prog.push_back(ins(8'h10, 8'd0, 8'd0, 8'd0));
        exp_q = '{8'd7};
        load();
        run = 1'b1;
        repeat (4) step();
        check("pause_pc_before", 32'(pc), 32'd3);
        run = 1'b0;
        repeat (2) step();
        check("pause_pc_frozen", 32'(pc), 32'd3);
        run = 1'b1;
        step();
        check("resume_pc", 32'(pc), 32'd3);
        prog_we = 1'b1; prog_addr = 8'd8; prog_wdata = ins(8'h10, 8'd0, 8'd0, 8'd0);
        step();
        prog_we = 1'b0;
        check("resume_pc_adv", 32'(pc), 32'd4);
        run_to_halt(30, cyc);
        check("prog_we_run_ignored_pc", 32'(pc), 32'd9);
        drain();
        stop();

        // Asynchronous reset during an output stall
        prog = '{ins(8'hC0, 8'h11, 8'd0, IO_A), ins(8'hC0, 8'h22, 8'd0, IO_A),
                 ins(8'h10, 8'd0, 8'd0, 8'd0)};
        io_out_ready = 1'b0;
        load();
        run = 1'b1;
        step();
        step();
        check("pre_rst_valid", 32'(io_out_valid), 32'd1);
        step();
        check("pre_rst_stall_pc", 32'(pc), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", 32'(io_out_valid), 32'd0);
        check("async_rst_out", 32'(io_out), 32'd0);
        check("async_rst_pc", 32'(pc), 32'd0);
        check("async_rst_in_ready", 32'(io_in_ready), 32'd0);
        run = 1'b0;
        for (int i = 0; i < 6; i++) m_regs[i] = 8'd0;
        #2 rst = 1'b1;
        step();

        // Randomized programs against the interpreter model
        for (int it = 0; it < 8; it++) begin
            gen_random(12, hidx);
            load();
            in_idx = 0; src_en = 1'b1; snk_en = 1'b1;
            run_to_halt(600, cyc);
            check("rand_halt_pc", 32'(pc), 32'(hidx));
            src_en = 1'b0; snk_en = 1'b0; io_in_valid = 1'b0;
            drain();
            check("rand_inputs_used", 32'(in_idx), 32'(in_vals.size()));
            stop();
        end

        // Wide configuration: PC write truncates, unmapped write is dropped
        begin
            logic [55:0] p2[$];
            p2 = '{ins16(8'hC0, 16'hFFFF, 16'd2, 16'd8), ins16(8'hC0, 16'h1234, 16'd0, 16'd11),
                   ins16(8'hC0, 16'hFFFF, 16'd2, 16'd9), ins16(8'h40, 16'd3, 16'd0, 16'd9),
                   ins16(8'h10, 16'd0, 16'd0, 16'd0)};
            exp2_q = '{16'h0001, 16'h0000};
            for (int i = 0; i < p2.size(); i++) begin
                prog_we2 = 1'b1; prog_addr2 = 4'(i); prog_wdata2 = p2[i];
                step();
            end
            prog_we2 = 1'b0;
            run2 = 1'b1;
            step();
            step();
            check("w16_pc_wrap", 32'(pc2), 32'd1);
            cyc = 0;
            while (!halted2 && cyc < 20) begin
                step();
                cyc++;
            end
            check("w16_halted", 32'(halted2), 32'd1);
            check("w16_halt_pc", 32'(pc2), 32'd4);
            check("w16_in_ready", 32'(io_in_ready2), 32'd0);
            repeat (3) step();
            check("w16_scoreboard_empty", 32'(exp2_q.size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/leg_core_p.md
# leg_core_p

Parametrised successor of the 8-bit LEG CPU top level: a single-issue LEG-style core with configurable data width, register count and program depth. It adds an internal loadable program store, a run/halt control FSM and valid/ready handshaking on the I/O port in place of the free-running, inverted I/O byte. It sits between the board I/O and the rest of the design, and executes one instruction per clock unless stalled.

## Interface
Parameters:
- DATA_W, 8: datapath, register and operand-field width.
- NUM_REGS, 6: general registers r0..r(NUM_REGS-1).
- PROG_DEPTH, 256: number of instruction words. PC_W = clog2(PROG_DEPTH).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  level; high lets the core execute.
- prog_we  in  1  program-store write strobe.
- prog_addr  in  PC_W  program-store write index.
- prog_wdata  in  8+3*DATA_W  instruction {opcode[7:0], arg_a, arg_b, dest}, opcode in the MSBs.
- io_in  in  DATA_W  input data.
- io_in_valid  in  1  io_in is valid.
- io_in_ready  out  1  core consumes io_in this cycle.
- io_out  out  DATA_W  output data (true polarity, not inverted).
- io_out_valid  out  1  io_out holds an unconsumed value.
- io_out_ready  in  1  sink accepts io_out.
- halted  out  1  core is in HALT.
- pc  out  PC_W  current instruction index.

## Operation
- Operand address space (arg_a, arg_b, dest):
  - 0..NUM_REGS-1 are the registers.
  - NUM_REGS is the PC.
  - NUM_REGS+1 is I/O.
  - Any other address reads 0; a write to it is dropped.
- Opcode bits:
  - [7] imm_a: arg_a is a literal.
  - [6] imm_b: arg_b is a literal.
  - [5] cond.
  - [4] HALT, which overrides all other bits.
  - [2:0] op.
- ALU ops (cond=0): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT a, 5 XOR, 6 SHL a by b mod DATA_W, 7 SHR (logical).
  - Results are truncated to DATA_W; there is no carry flag.
  - The result is written to dest.
- Condition ops (cond=1), unsigned compare: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6 ALWAYS, 7 NEVER.
  - If the condition is true, PC <= dest[PC_W-1:0]. Otherwise PC <= PC+1.
  - No register is written.
- PC handling:
  - Normal retire: PC <= PC+1, wrapping PROG_DEPTH-1 -> 0.
  - An ALU write to the PC address sets PC <= result[PC_W-1:0]; there is no increment.
  - Reading the PC address returns the current PC, zero-extended.
- Fetch is combinational from the program store at pc.
  - The store is written only in IDLE or HALT; prog_we in RUN is ignored.
  - The store is not reset.
- FSM states: IDLE, RUN, HALT.
  - IDLE -> RUN when run=1. Execution starts at the current pc.
  - RUN -> IDLE when run=0. No instruction retires that cycle and pc is held.
  - RUN -> HALT when a HALT instruction retires. pc is held at the HALT instruction.
  - HALT -> IDLE when run=0, with pc <= 0.
- Input stall: an instruction that reads I/O on either operand:
  - drives io_in_ready=1 while in RUN;
  - retires only in a cycle with io_in_valid=1;
  - if both operands are I/O, they see the same single value.
- Output stall: an instruction writing I/O stalls while io_out_valid=1 and io_out_ready=0.
  - It retires when io_out_valid=0 or io_out_ready=1.
  - On retire, io_out <= result and io_out_valid <= 1.
- io_out_valid clears on a cycle with io_out_ready=1 and no new I/O write.
- A single instruction that both reads and writes I/O waits for both conditions.
- A stall holds all architectural state.

## Timing
- Reset values:
  - pc=0, all registers 0, state IDLE;
  - io_out=0, io_out_valid=0, io_in_ready=0, halted=0.
- One instruction retires per clock in RUN with no stall. Register and PC updates are visible to the next instruction; there are no hazards.
- io_in_ready is combinational from state, the fetched opcode/args and run. It is 0 outside RUN.
- io_out and io_out_valid are registered: valid rises 1 cycle after the writing instruction retires.
- halted is registered: it is high the cycle after the HALT instruction retires.
- A prog_we in IDLE updates the store at the edge; a fetch at that index sees the new word the next cycle.
- rst mid-stall aborts the instruction with no partial writes, and io_out_valid drops immediately (async).

## Test plan
- ALU smoke test, DATA_W=8. Load: ADD imm 200+100 -> r0; SUB imm 5-7 -> r1; SHL r0 by imm 9 -> r2; HALT. Run -> r0=44, r1=0xFE, r2=0x58, halted=1 after 4 retires, pc=3.
- Loop. Load: r0=0; ADD r0+1 -> r0; LT r0,imm 10 jump 1; copy r0 -> I/O; HALT, with io_out_ready=1. Run -> io_out=10, io_out_valid pulses exactly once, halted=1.
- Input stall. Load: ADD I/O,I/O -> r0. Hold io_in_valid=0 for 5 cycles, then 0x21 for 1 cycle -> pc constant and io_in_ready=1 during the stall, r0=0x42, pc advances once.
- Output back-pressure. Two consecutive writes of 0xAA and 0x55 to I/O, io_out_ready=0 for 3 cycles -> io_out holds 0xAA with valid=1, the second write stalls, 0x55 appears the cycle after ready rises.
- Parameter sweep. DATA_W=16, NUM_REGS=8, PROG_DEPTH=16; ADD imm 0xFFFF+2 -> PC address 8 -> pc wraps to 1 (truncated); write to address 11 is dropped.
- Control. Deassert run mid-program -> pc frozen, IDLE. prog_we in RUN has no effect. Assert rst during an output stall -> all outputs at reset values asynchronously.
